// File: rtl/aes_uart_host_ctrl.sv
// Host-side UART initiator for the AES core: sends 16 key + 16 plaintext bytes (8N1), collects 16 ciphertext bytes.
// Defining HOST_FRAMING_CHECK_EN adds stop-bit checking and a sticky frame_err output.
module aes_uart_host_ctrl #(
   parameter logic [23:0] BAUD_RATE      = 24'd4000000,
   parameter logic [27:0] CLOCK_FREQ     = 28'd50000000,
   parameter int          GAP_CYCLES     = 16,
   parameter int          SETUP_CYCLES   = 8,
   parameter int          DROP_CYCLES    = 8,
   parameter int          TIMEOUT_CYCLES = 200000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         new_key,
   input  logic [127:0] key_in,
   input  logic [127:0] pt_in,
   output logic         uart_tx,
   input  logic         uart_rx,
   output logic         aes_enable,
   output logic         busy,
   output logic [127:0] ct_out,
   output logic         ct_valid,
   output logic         timeout_err
`ifdef HOST_FRAMING_CHECK_EN
   ,
   output logic         frame_err
`endif
);

   localparam int          CLKS_PER_BIT = int'(CLOCK_FREQ / BAUD_RATE);
   localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] SETUP_LAST   = 16'(SETUP_CYCLES - 1);
   localparam logic [15:0] DROP_LAST    = 16'(DROP_CYCLES - 1);
   localparam int          TMO_W        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_DROP, S_SETUP, S_SEND_KEY, S_SEND_PT, S_RECV_CT, S_DONE, S_ERROR
   } state_t;

   state_t           state_q;
   logic [15:0]      phase_cnt_q, tx_cnt_q, rx_cnt_q;
   logic [3:0]       tx_bit_q, tx_idx_q, rx_bit_q, rx_idx_q;
   logic [7:0]       rx_shift_q;
   logic [2:0]       rx_sync_q;
   logic             rx_act_q, key_loaded_q;
   logic [127:0]     key_q, pt_q, ct_shadow_q, ct_out_q;
   logic [TMO_W-1:0] tmo_q;
   logic             uart_tx_q, aes_enable_q, busy_q, ct_valid_q, timeout_err_q;
`ifdef HOST_FRAMING_CHECK_EN
   logic             frame_err_q;
   assign frame_err = frame_err_q;
`endif

   logic       accept, rx_s, rx_fall, rx_tick, tx_bit_end, tx_next_lvl;
   logic [6:0] tx_sel;
   logic [7:0] tx_byte;

   assign accept     = start && !busy_q;
   assign rx_s       = rx_sync_q[1];
   assign rx_fall    = rx_sync_q[2] && !rx_sync_q[1];
   assign rx_tick    = rx_act_q && ((rx_bit_q == 4'd0) ? (rx_cnt_q == HALF_LAST) : (rx_cnt_q == BIT_LAST));
   // tx_bit_q: 0 start, 1..8 data, 9 stop, 10 inter-byte gap
   assign tx_bit_end = (tx_bit_q == 4'd10) ? (tx_cnt_q == GAP_LAST) : (tx_cnt_q == BIT_LAST);
   assign tx_sel     = {tx_idx_q, 3'b000};
   assign tx_byte    = (state_q == S_SEND_KEY) ? key_q[tx_sel +: 8] : pt_q[tx_sel +: 8];

   always_comb begin
      tx_next_lvl = 1'b1;
      if (tx_bit_q < 4'd8) tx_next_lvl = tx_byte[tx_bit_q[2:0]];
   end

   assign uart_tx     = uart_tx_q;
   assign aes_enable  = aes_enable_q;
   assign busy        = busy_q;
   assign ct_out      = ct_out_q;
   assign ct_valid    = ct_valid_q;
   assign timeout_err = timeout_err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         phase_cnt_q   <= '0;
         tx_cnt_q      <= '0;
         rx_cnt_q      <= '0;
         tx_bit_q      <= '0;
         tx_idx_q      <= '0;
         rx_bit_q      <= '0;
         rx_idx_q      <= '0;
         rx_shift_q    <= '0;
         rx_sync_q     <= '1;
         rx_act_q      <= 1'b0;
         key_loaded_q  <= 1'b0;
         key_q         <= '0;
         pt_q          <= '0;
         ct_shadow_q   <= '0;
         ct_out_q      <= '0;
         tmo_q         <= '0;
         uart_tx_q     <= 1'b1;
         aes_enable_q  <= 1'b0;
         busy_q        <= 1'b0;
         ct_valid_q    <= 1'b0;
         timeout_err_q <= 1'b0;
`ifdef HOST_FRAMING_CHECK_EN
         frame_err_q   <= 1'b0;
`endif
      end else begin
         rx_sync_q  <= {rx_sync_q[1:0], uart_rx};
         ct_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               busy_q <= 1'b0;
               if (accept) begin
                  busy_q        <= 1'b1;
                  timeout_err_q <= 1'b0;
`ifdef HOST_FRAMING_CHECK_EN
                  frame_err_q   <= 1'b0;
`endif
                  key_q         <= key_in;
                  pt_q          <= pt_in;
                  phase_cnt_q   <= '0;
                  tx_idx_q      <= '0;
                  if (aes_enable_q && (new_key || !key_loaded_q)) begin
                     state_q      <= S_DROP;
                     aes_enable_q <= 1'b0;
                     key_loaded_q <= 1'b0;
                  end else if (!aes_enable_q) begin
                     state_q      <= S_SETUP;
                     aes_enable_q <= 1'b1;
                  end else begin
                     state_q   <= S_SEND_PT;
                     uart_tx_q <= 1'b0;
                     tx_bit_q  <= '0;
                     tx_cnt_q  <= '0;
                  end
               end
            end
            S_DROP: begin
               if (phase_cnt_q == DROP_LAST) begin
                  state_q      <= S_SETUP;
                  aes_enable_q <= 1'b1;
                  phase_cnt_q  <= '0;
               end else begin
                  phase_cnt_q <= phase_cnt_q + 16'd1;
               end
            end
            S_SETUP: begin
               if (phase_cnt_q == SETUP_LAST) begin
                  state_q   <= S_SEND_KEY;
                  uart_tx_q <= 1'b0;
                  tx_bit_q  <= '0;
                  tx_cnt_q  <= '0;
                  tx_idx_q  <= '0;
               end else begin
                  phase_cnt_q <= phase_cnt_q + 16'd1;
               end
            end
            S_SEND_KEY, S_SEND_PT: begin
               if (!tx_bit_end) begin
                  tx_cnt_q <= tx_cnt_q + 16'd1;
               end else if (tx_bit_q != 4'd10) begin
                  tx_cnt_q  <= '0;
                  tx_bit_q  <= tx_bit_q + 4'd1;
                  uart_tx_q <= tx_next_lvl;
               end else begin
                  // gap over: next start bit follows immediately, also across the key/plaintext boundary
                  tx_cnt_q <= '0;
                  tx_bit_q <= '0;
                  tx_idx_q <= tx_idx_q + 4'd1;
                  if (tx_idx_q != 4'd15 || state_q == S_SEND_KEY) uart_tx_q <= 1'b0;
                  if (tx_idx_q == 4'd15) begin
                     if (state_q == S_SEND_KEY) begin
                        key_loaded_q <= 1'b1;
                        state_q      <= S_SEND_PT;
                     end else begin
                        state_q  <= S_RECV_CT;
                        tmo_q    <= '0;
                        rx_act_q <= 1'b0;
                        rx_idx_q <= '0;
                     end
                  end
               end
            end
            S_RECV_CT: begin
               tmo_q <= tmo_q + TMO_W'(1);
               if (tmo_q == TMO_LAST) state_q <= S_ERROR;
               if (!rx_act_q) begin
                  if (rx_fall) begin
                     rx_act_q <= 1'b1;
                     rx_cnt_q <= '0;
                     rx_bit_q <= '0;
                  end
               end else if (!rx_tick) begin
                  rx_cnt_q <= rx_cnt_q + 16'd1;
               end else begin
                  rx_cnt_q <= '0;
                  rx_bit_q <= rx_bit_q + 4'd1;
                  if (rx_bit_q == 4'd0) begin
                     if (rx_s) rx_act_q <= 1'b0;
                  end else if (rx_bit_q != 4'd9) begin
                     rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                  end else begin
                     rx_act_q <= 1'b0;
`ifdef HOST_FRAMING_CHECK_EN
                     if (!rx_s) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_ERROR;
                     end else
`endif
                     begin
                        ct_shadow_q[{rx_idx_q, 3'b000} +: 8] <= rx_shift_q;
                        rx_idx_q <= rx_idx_q + 4'd1;
                        tmo_q    <= '0;
                        if (rx_idx_q == 4'd15) state_q <= S_DONE;
                     end
                  end
               end
            end
            S_DONE: begin
               ct_out_q   <= ct_shadow_q;
               ct_valid_q <= 1'b1;
               state_q    <= S_IDLE;
            end
            S_ERROR: begin
               timeout_err_q <= 1'b1;
               aes_enable_q  <= 1'b0;
               key_loaded_q  <= 1'b0;
               state_q       <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_uart_host_ctrl.sv
// Directed bench for aes_uart_host_ctrl: checks line waveforms bit-for-bit and plays the AES core's reply.
module tb_aes_uart_host_ctrl;

   logic         clk = 1'b0;
   logic         reset, start, new_key, uart_rx;
   logic [127:0] key_in, pt_in;
   logic         uart_tx, aes_enable, busy, ct_valid, timeout_err;
   logic [127:0] ct_out;
`ifdef HOST_FRAMING_CHECK_EN
   logic         frame_err;
`endif

   always #5 clk = ~clk;

   aes_uart_host_ctrl #(.TIMEOUT_CYCLES(3000)) dut (
      .clk(clk), .reset(reset), .start(start), .new_key(new_key),
      .key_in(key_in), .pt_in(pt_in), .uart_tx(uart_tx), .uart_rx(uart_rx),
      .aes_enable(aes_enable), .busy(busy), .ct_out(ct_out), .ct_valid(ct_valid),
      .timeout_err(timeout_err)
`ifdef HOST_FRAMING_CHECK_EN
      , .frame_err(frame_err)
`endif
   );

   localparam logic [127:0] K1 = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] P1 = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] R1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
   localparam logic [127:0] P2 = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] R2 = 128'hc3a51e7f00ff80015aa5c33c96694bb4;
   localparam logic [127:0] K3 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P3 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] R3 = 128'h3925841d02dc09fbdc118597196a0b32;

   int   vectors = 0, miscompares = 0;
   int   vld_cnt, aes_low_cnt, n;
   logic last_vld, busy_after, vld_after;

   task automatic chk(input logic [127:0] obs, input logic [127:0] exp, input string tag);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (last_vld) begin
         busy_after = busy;
         vld_after  = ct_valid;
      end
      if (ct_valid) vld_cnt++;
      if (!aes_enable) aes_low_cnt++;
      last_vld = ct_valid;
   endtask

   task automatic pulse_start(input logic nk);
      start = 1'b1; new_key = nk;
      tick();
      start = 1'b0; new_key = 1'b0;
   endtask

   task automatic count_setup(input string tag);
      n = 0;
      while (uart_tx && aes_enable && n < 100) begin n++; tick(); end
      chk(128'(n), 128'd8, tag);
   endtask

   task automatic wait_tx_fall(input string tag);
      n = 0;
      while (uart_tx && n < 2000) begin n++; tick(); end
      chk(128'(uart_tx), 128'd0, tag);
   endtask

   task automatic wait_idle(input string tag);
      n = 0;
      while (busy && n < 8000) begin n++; tick(); end
      chk(128'(busy), 128'd0, tag);
   endtask

   // one 136-cycle byte slot: 12 start, 8x12 data LSB first, 12 stop, 16 gap
   task automatic tx_frame(input logic [7:0] exp, input string tag);
      logic [7:0] got, e_sh;
      logic       e;
      int         bad;
      got = '0; bad = 0;
      for (int i = 0; i < 136; i++) begin
         if (i < 12) e = 1'b0;
         else if (i < 108) begin e_sh = exp >> ((i - 12) / 12); e = e_sh[0]; end
         else e = 1'b1;
         if (uart_tx !== e) bad++;
         if (i >= 12 && i < 108 && (i - 12) % 12 == 6) got = {uart_tx, got[7:1]};
         tick();
      end
      chk(128'({bad, got}), 128'({32'd0, exp}), tag);
   endtask

   task automatic send_bytes(input logic [127:0] k, input logic [127:0] p, input logic with_key);
      if (with_key)
         for (int j = 0; j < 16; j++) tx_frame(8'(k >> (8 * j)), $sformatf("key byte %0d", j));
      for (int j = 0; j < 16; j++) tx_frame(8'(p >> (8 * j)), $sformatf("pt byte %0d", j));
   endtask

   task automatic rx_byte(input logic [7:0] b);
      logic [7:0] s;
      s = b;
      uart_rx = 1'b0; repeat (12) tick();
      for (int i = 0; i < 8; i++) begin
         uart_rx = s[0]; s = s >> 1;
         repeat (12) tick();
      end
      uart_rx = 1'b1; repeat (16) tick();
   endtask

   task automatic respond(input logic [127:0] r, input int nbytes);
      vld_cnt = 0; busy_after = 1'b1; vld_after = 1'b1;
      for (int j = 0; j < nbytes; j++) rx_byte(8'(r >> (8 * j)));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; new_key = 1'b0; uart_rx = 1'b1;
      key_in = '0; pt_in = '0;
      vld_cnt = 0; aes_low_cnt = 0; last_vld = 1'b0; busy_after = 1'b1; vld_after = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk(128'({uart_tx, aes_enable, busy, ct_valid, timeout_err}), 128'(5'b10000), "reset outputs");
      chk(ct_out, 128'd0, "reset ct_out");
`ifdef HOST_FRAMING_CHECK_EN
      chk(128'(frame_err), 128'd0, "reset frame_err");
`endif

      // first transaction: setup, full key + plaintext; inputs changed after capture
      key_in = K1; pt_in = P1;
      pulse_start(1'b0);
      chk(128'({aes_enable, busy}), 128'(2'b11), "t1 accept");
      key_in = '0; pt_in = '0;
      count_setup("t1 setup cycles");
      send_bytes(K1, P1, 1'b1);
      respond(R1, 16);
      wait_idle("t1 busy drop");
      chk(ct_out, R1, "t1 ct_out");
      chk(128'(vld_cnt), 128'd1, "t1 ct_valid pulses");
      chk(128'({busy_after, vld_after}), 128'd0, "t1 busy/valid after pulse");
      chk(128'(aes_enable), 128'd1, "t1 enable held");

      // key held by core: plaintext only, enable never drops, start while busy ignored
      pt_in = P2; key_in = K3; aes_low_cnt = 0;
      pulse_start(1'b0);
      wait_tx_fall("t2 tx start");
      send_bytes(K3, P2, 1'b0);
      start = 1'b1; new_key = 1'b1; tick(); start = 1'b0; new_key = 1'b0;
      respond(R2, 16);
      wait_idle("t2 busy drop");
      chk(ct_out, R2, "t2 ct_out");
      chk(128'(vld_cnt), 128'd1, "t2 ct_valid pulses");
      chk(128'(aes_low_cnt), 128'd0, "t2 enable low cycles");

      // forced re-key: 8 cycles low, 8 setup, 32 bytes
      key_in = K3; pt_in = P3;
      pulse_start(1'b1);
      n = 0;
      while (!aes_enable && n < 100) begin n++; tick(); end
      chk(128'(n), 128'd8, "t3 drop cycles");
      count_setup("t3 setup cycles");
      send_bytes(K3, P3, 1'b1);
      respond(R3, 16);
      wait_idle("t3 busy drop");
      chk(ct_out, R3, "t3 ct_out");

      // only 15 reply bytes: timeout path
      pt_in = P1;
      pulse_start(1'b0);
      wait_tx_fall("t4 tx start");
      send_bytes(K3, P1, 1'b0);
      respond(R1, 15);
      wait_idle("t4 busy drop");
      chk(128'({timeout_err, aes_enable}), 128'(2'b10), "t4 err/enable");
      chk(ct_out, R3, "t4 ct_out unchanged");
      chk(128'(vld_cnt), 128'd0, "t4 no ct_valid");

      // recovery start clears the error and resends the key
      pulse_start(1'b0);
      chk(128'({timeout_err, busy, aes_enable}), 128'(3'b011), "t5 accept");
      count_setup("t5 setup cycles");
      send_bytes(K3, P1, 1'b1);
      respond(R1, 16);
      wait_idle("t5 busy drop");
      chk(ct_out, R1, "t5 ct_out");

      // reset in the middle of plaintext byte 0 (d1 of 0x00 on the line)
      pulse_start(1'b0);
      repeat (30) tick();
      chk(128'({uart_tx, busy}), 128'(2'b01), "t6 mid-byte line");
      reset = 1'b1;
      tick();
      chk(128'({uart_tx, aes_enable, busy, ct_valid, timeout_err}), 128'(5'b10000), "t6 reset outputs");
      chk(ct_out, 128'd0, "t6 reset ct_out");
      reset = 1'b0;
      tick();

      // 1-cycle low glitch in RECV_CT must not produce a byte
      key_in = K1; pt_in = P2;
      pulse_start(1'b0);
      count_setup("t7 setup cycles");
      send_bytes(K1, P2, 1'b1);
      uart_rx = 1'b0; tick(); uart_rx = 1'b1;
      repeat (40) tick();
      chk(128'(busy), 128'd1, "t7 still receiving");
      respond(R2, 16);
      wait_idle("t7 busy drop");
      chk(ct_out, R2, "t7 ct_out");
      chk(128'(vld_cnt), 128'd1, "t7 ct_valid pulses");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
